// File: rtl/lsu_ctrl.sv
// Load/store sequencer: one command in flight, ISSUE strobe, fixed MEM_LAT wait, one-cycle load writeback.
// Latency: store 2 cycles, load MEM_LAT+3 cycles; in_ready low while busy. Optional LSU_BOUNDS_CHECK_EN.
module lsu_ctrl #(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 8,
   parameter int MEM_DEPTH = 4,
   parameter int MEM_LAT   = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_op,
   input  logic [1:0]        in_reg,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [DATA_W-1:0] in_data,
   output logic              mem_run,
   output logic              mem_op,
   output logic [1:0]        mem_reg,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              wb_valid,
   output logic [1:0]        wb_reg,
   output logic [DATA_W-1:0] wb_data,
   output logic              fault,
   output logic              busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_WB    = 2'd3
   } state_t;

   localparam logic [2:0] LAT_LAST = 3'(MEM_LAT - 1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [2:0]        r_cnt;
   logic [2:0]        w_cnt_nxt;
   logic              w_capture;
   logic              w_accept;
   logic              w_fault_flag;
   logic              r_op;
   logic [1:0]        r_reg;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_wb_data;

   assign w_accept = in_valid & (r_state == S_IDLE);

`ifdef LSU_BOUNDS_CHECK_EN
   logic r_fault;
   logic w_addr_oob;

   assign w_addr_oob = (32'(in_addr) >= 32'(MEM_DEPTH));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fault <= 1'b0;
      end else if (w_accept) begin
         r_fault <= w_addr_oob;
      end
   end

   assign w_fault_flag = r_fault;
`else
   logic w_unused_depth;

   assign w_unused_depth = (MEM_DEPTH == 0);
   assign w_fault_flag   = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= 3'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Command fields persist until the next accept; faulting commands latch too.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op    <= 1'b0;
         r_reg   <= 2'd0;
         r_addr  <= '0;
         r_wdata <= '0;
      end else if (w_accept) begin
         r_op    <= in_op;
         r_reg   <= in_reg;
         r_addr  <= in_addr;
         r_wdata <= in_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wb_data <= '0;
      end else if (w_capture) begin
         r_wb_data <= mem_rdata;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_capture   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (in_valid) begin
               w_state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (r_op || w_fault_flag) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_WAIT;
               w_cnt_nxt   = 3'd0;
            end
         end
         S_WAIT: begin
            w_cnt_nxt = r_cnt + 3'd1;
            // Read data is valid on the edge that closes the last wait cycle.
            if (r_cnt == LAT_LAST) begin
               w_state_nxt = S_WB;
               w_capture   = 1'b1;
            end
         end
         S_WB: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign in_ready  = (r_state == S_IDLE);
   assign busy      = ~in_ready;
   assign mem_run   = (r_state == S_ISSUE) & ~w_fault_flag;
   assign fault     = (r_state == S_ISSUE) & w_fault_flag;
   assign mem_op    = r_op;
   assign mem_reg   = r_reg;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign wb_valid  = (r_state == S_WB);
   assign wb_reg    = (r_state == S_WB) ? r_reg : 2'd0;
   assign wb_data   = r_wb_data;

endmodule
